// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch and
// data channels of the MIPS core. Only one transaction is outstanding at a time.
// Each response is routed back to the channel that made the request.
// Optional build macro ARB_PERF_CNT_EN adds grant and wait-cycle counters.
//
//   state  | meaning
//   IDLE   | no transaction; arbitrate pending requests
//   I_REQ  | fetch request driven on the memory port, waiting for mem_req_ack
//   I_RESP | waiting for the fetch response handshake
//   D_REQ  | data read/write driven on the memory port, waiting for mem_req_ack
//   D_RESP | waiting for the data read response handshake
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_pc,
    input  logic        cpu_inst_req_valid,
    output logic        cpu_inst_req_ack,
    output logic [31:0] cpu_instruction,
    output logic        cpu_inst_valid,
    input  logic        cpu_inst_ack,
    input  logic [31:0] cpu_address,
    input  logic        cpu_mem_write,
    input  logic [31:0] cpu_write_data,
    input  logic [3:0]  cpu_write_strb,
    input  logic        cpu_mem_read,
    output logic        cpu_mem_req_ack,
    output logic [31:0] cpu_read_data,
    output logic        cpu_read_data_valid,
    input  logic        cpu_read_data_ack,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_strb,
    output logic        mem_read,
    input  logic        mem_req_ack,
    input  logic [31:0] mem_read_data,
    input  logic        mem_read_data_valid,
    output logic        mem_read_data_ack,
    output logic [31:0] perf_inst_grants,
    output logic [31:0] perf_data_grants,
    output logic [31:0] perf_wait_cycles
);

    typedef enum logic [2:0] {IDLE, I_REQ, I_RESP, D_REQ, D_RESP} state_t;

    state_t      state, state_nxt;
    logic        last_grant_data;   // 0: fetch was granted last, 1: data
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        req_write;
    logic        d_pend, i_pend, grant_d, grant_i;

    assign d_pend  = cpu_mem_read | cpu_mem_write;
    assign i_pend  = cpu_inst_req_valid;
    // On a tie the side that did not win last time gets the port.
    assign grant_d = (state == IDLE) && d_pend && (!i_pend || !last_grant_data);
    assign grant_i = (state == IDLE) && i_pend && !grant_d;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Capture the granted request so the requester may change it after its ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr        <= '0;
            req_wdata       <= '0;
            req_strb        <= '0;
            req_write       <= 1'b0;
            last_grant_data <= 1'b0;
        end else if (grant_d) begin
            req_addr        <= cpu_address;
            req_wdata       <= cpu_write_data;
            req_strb        <= cpu_write_strb;
            req_write       <= cpu_mem_write;   // read+write together counts as a write
            last_grant_data <= 1'b1;
        end else if (grant_i) begin
            req_addr        <= cpu_pc;
            req_wdata       <= '0;
            req_strb        <= '0;
            req_write       <= 1'b0;
            last_grant_data <= 1'b0;
        end
    end

    // Next-state logic and routing of the port to the current owner.
    always_comb begin
        state_nxt           = state;
        cpu_inst_req_ack    = 1'b0;
        cpu_instruction     = '0;
        cpu_inst_valid      = 1'b0;
        cpu_mem_req_ack     = 1'b0;
        cpu_read_data       = '0;
        cpu_read_data_valid = 1'b0;
        mem_address         = '0;
        mem_write           = 1'b0;
        mem_write_data      = '0;
        mem_write_strb      = '0;
        mem_read            = 1'b0;
        mem_read_data_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d)      state_nxt = D_REQ;
                else if (grant_i) state_nxt = I_REQ;
            end
            I_REQ: begin
                mem_address      = req_addr;
                mem_read         = 1'b1;
                cpu_inst_req_ack = mem_req_ack;
                if (mem_req_ack) state_nxt = I_RESP;
            end
            I_RESP: begin
                cpu_instruction   = mem_read_data;
                cpu_inst_valid    = mem_read_data_valid;
                mem_read_data_ack = cpu_inst_ack;
                if (mem_read_data_valid && cpu_inst_ack) state_nxt = IDLE;
            end
            D_REQ: begin
                mem_address     = req_addr;
                mem_write       = req_write;
                mem_read        = !req_write;
                mem_write_data  = req_wdata;
                mem_write_strb  = req_strb;
                cpu_mem_req_ack = mem_req_ack;
                if (mem_req_ack) state_nxt = req_write ? IDLE : D_RESP;
            end
            D_RESP: begin
                cpu_read_data       = mem_read_data;
                cpu_read_data_valid = mem_read_data_valid;
                mem_read_data_ack   = cpu_read_data_ack;
                if (mem_read_data_valid && cpu_read_data_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] inst_cnt, data_cnt, wait_cnt;
    logic        wait_now;

    // A requester is stalled by the other channel's transaction or by losing a tie.
    assign wait_now = (((state == I_REQ) || (state == I_RESP)) && d_pend) ||
                      (((state == D_REQ) || (state == D_RESP)) && i_pend) ||
                      ((state == IDLE) && d_pend && i_pend);

    // Free-running wrapping counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_cnt <= '0;
            data_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            if (grant_i)  inst_cnt <= inst_cnt + 32'd1;
            if (grant_d)  data_cnt <= data_cnt + 32'd1;
            if (wait_now) wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign perf_inst_grants = inst_cnt;
    assign perf_data_grants = data_cnt;
    assign perf_wait_cycles = wait_cnt;
`else
    assign perf_inst_grants = '0;
    assign perf_data_grants = '0;
    assign perf_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a table of per-cycle vectors plus
// hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        inst_req;
        logic [31:0] pc;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        inst_ack;
        logic        rd_ack;
        logic        mreq_ack;
        logic        mrvalid;
        logic [31:0] mrdata;
    } in_t;

    typedef struct packed {
        logic        mem_read;
        logic        mem_write;
        logic [31:0] mem_address;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_strb;
        logic        i_req_ack;
        logic        d_req_ack;
        logic        inst_valid;
        logic [31:0] instruction;
        logic        rd_valid;
        logic [31:0] read_data;
        logic        mem_rd_ack;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_pc = '0;
    logic        cpu_inst_req_valid = 1'b0;
    logic        cpu_inst_req_ack;
    logic [31:0] cpu_instruction;
    logic        cpu_inst_valid;
    logic        cpu_inst_ack = 1'b0;
    logic [31:0] cpu_address = '0;
    logic        cpu_mem_write = 1'b0;
    logic [31:0] cpu_write_data = '0;
    logic [3:0]  cpu_write_strb = '0;
    logic        cpu_mem_read = 1'b0;
    logic        cpu_mem_req_ack;
    logic [31:0] cpu_read_data;
    logic        cpu_read_data_valid;
    logic        cpu_read_data_ack = 1'b0;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_strb;
    logic        mem_read;
    logic        mem_req_ack = 1'b0;
    logic [31:0] mem_read_data = '0;
    logic        mem_read_data_valid = 1'b0;
    logic        mem_read_data_ack;
    logic [31:0] perf_inst_grants, perf_data_grants, perf_wait_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_pc(cpu_pc), .cpu_inst_req_valid(cpu_inst_req_valid),
        .cpu_inst_req_ack(cpu_inst_req_ack), .cpu_instruction(cpu_instruction),
        .cpu_inst_valid(cpu_inst_valid), .cpu_inst_ack(cpu_inst_ack),
        .cpu_address(cpu_address), .cpu_mem_write(cpu_mem_write),
        .cpu_write_data(cpu_write_data), .cpu_write_strb(cpu_write_strb),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_req_ack(cpu_mem_req_ack),
        .cpu_read_data(cpu_read_data), .cpu_read_data_valid(cpu_read_data_valid),
        .cpu_read_data_ack(cpu_read_data_ack),
        .mem_address(mem_address), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_write_strb(mem_write_strb),
        .mem_read(mem_read), .mem_req_ack(mem_req_ack),
        .mem_read_data(mem_read_data), .mem_read_data_valid(mem_read_data_valid),
        .mem_read_data_ack(mem_read_data_ack),
        .perf_inst_grants(perf_inst_grants), .perf_data_grants(perf_data_grants),
        .perf_wait_cycles(perf_wait_cycles)
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t s;
        s.mem_read    = mem_read;
        s.mem_write   = mem_write;
        s.mem_address = mem_address;
        s.mem_wdata   = mem_write_data;
        s.mem_strb    = mem_write_strb;
        s.i_req_ack   = cpu_inst_req_ack;
        s.d_req_ack   = cpu_mem_req_ack;
        s.inst_valid  = cpu_inst_valid;
        s.instruction = cpu_instruction;
        s.rd_valid    = cpu_read_data_valid;
        s.read_data   = cpu_read_data;
        s.mem_rd_ack  = mem_read_data_ack;
        return s;
    endfunction

    task automatic drive(input in_t x);
        cpu_inst_req_valid  = x.inst_req;
        cpu_pc              = x.pc;
        cpu_mem_read        = x.rd;
        cpu_mem_write       = x.wr;
        cpu_address         = x.addr;
        cpu_write_data      = x.wdata;
        cpu_write_strb      = x.strb;
        cpu_inst_ack        = x.inst_ack;
        cpu_read_data_ack   = x.rd_ack;
        mem_req_ack         = x.mreq_ack;
        mem_read_data_valid = x.mrvalid;
        mem_read_data       = x.mrdata;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Serve one read transaction: wait for the grant, check the owner by its
    // address, ack the request, then return rdata with a one-cycle handshake.
    task automatic run_read(input bit is_inst, input logic [31:0] exp_addr,
                            input logic [31:0] rdata, input string tag);
        int n = 0;
        @(negedge clk);
        while (!mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mem_read) begin
            chk({tag, "_grant_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_grant_addr"}, mem_address, exp_addr);
            mem_req_ack = 1'b1;
            #1;
            chk({tag, "_req_ack"}, {30'd0, cpu_inst_req_ack, cpu_mem_req_ack},
                is_inst ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            mem_req_ack         = 1'b0;
            mem_read_data_valid = 1'b1;
            mem_read_data       = rdata;
            if (is_inst) begin
                cpu_inst_req_valid = 1'b0;
                cpu_inst_ack       = 1'b1;
            end else begin
                cpu_mem_read      = 1'b0;
                cpu_read_data_ack = 1'b1;
            end
            @(negedge clk);
            chk({tag, "_resp_data"}, is_inst ? cpu_instruction : cpu_read_data, rdata);
            chk({tag, "_resp_valid"}, {29'd0, cpu_inst_valid, cpu_read_data_valid,
                mem_read_data_ack}, is_inst ? 32'd5 : 32'd3);
            @(posedge clk); #1;
            mem_read_data_valid = 1'b0;
            mem_read_data       = '0;
            cpu_inst_ack        = 1'b0;
            cpu_read_data_ack   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive('0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    localparam int NV = 21;
    vec_t vecs [NV];

    initial begin
        // Per-cycle vectors, starting from IDLE right after reset.
        vecs[0].i  = '{inst_req:1'b1, pc:32'h100, default:'0};
        vecs[0].o  = '0;
        vecs[1].i  = '{inst_req:1'b1, pc:32'h100, mreq_ack:1'b1, default:'0};
        vecs[1].o  = '{mem_read:1'b1, mem_address:32'h100, i_req_ack:1'b1, default:'0};
        vecs[2].i  = '0;
        vecs[2].o  = '0;
        vecs[3].i  = '{inst_ack:1'b1, mrvalid:1'b1, mrdata:32'h2408000A, default:'0};
        vecs[3].o  = '{inst_valid:1'b1, instruction:32'h2408000A, mem_rd_ack:1'b1, default:'0};
        vecs[4].i  = '{mrvalid:1'b1, mrdata:32'h55555555, inst_ack:1'b1, rd_ack:1'b1, default:'0};
        vecs[4].o  = '0;
        vecs[5].i  = '{wr:1'b1, addr:32'h1000, wdata:32'hDEADBEEF, strb:4'hF, default:'0};
        vecs[5].o  = '0;
        vecs[6].i  = vecs[5].i;
        vecs[6].o  = '{mem_write:1'b1, mem_address:32'h1000, mem_wdata:32'hDEADBEEF,
                       mem_strb:4'hF, default:'0};
        vecs[7].i  = '{wr:1'b1, addr:32'h1000, wdata:32'hDEADBEEF, strb:4'hF,
                       mreq_ack:1'b1, default:'0};
        vecs[7].o  = '{mem_write:1'b1, mem_address:32'h1000, mem_wdata:32'hDEADBEEF,
                       mem_strb:4'hF, d_req_ack:1'b1, default:'0};
        vecs[8].i  = '{mrvalid:1'b1, rd_ack:1'b1, default:'0};
        vecs[8].o  = '0;
        vecs[9].i  = '{rd:1'b1, wr:1'b1, addr:32'h2000, wdata:32'h12345678, strb:4'h3, default:'0};
        vecs[9].o  = '0;
        vecs[10].i = '{rd:1'b1, wr:1'b1, addr:32'h2000, wdata:32'h12345678, strb:4'h3,
                       mreq_ack:1'b1, default:'0};
        vecs[10].o = '{mem_write:1'b1, mem_address:32'h2000, mem_wdata:32'h12345678,
                       mem_strb:4'h3, d_req_ack:1'b1, default:'0};
        vecs[11].i = '{rd:1'b1, addr:32'h3000, default:'0};
        vecs[11].o = '0;
        vecs[12].i = '{rd:1'b1, addr:32'h3000, mreq_ack:1'b1, default:'0};
        vecs[12].o = '{mem_read:1'b1, mem_address:32'h3000, d_req_ack:1'b1, default:'0};
        vecs[13].i = '{inst_req:1'b1, pc:32'h104, mrvalid:1'b1, mrdata:32'hCAFEF00D, default:'0};
        vecs[13].o = '{rd_valid:1'b1, read_data:32'hCAFEF00D, default:'0};
        vecs[14].i = '{inst_req:1'b1, pc:32'h104, mrvalid:1'b1, mrdata:32'hCAFEF00D,
                       rd_ack:1'b1, default:'0};
        vecs[14].o = '{rd_valid:1'b1, read_data:32'hCAFEF00D, mem_rd_ack:1'b1, default:'0};
        vecs[15].i = '{inst_req:1'b1, pc:32'h104, default:'0};
        vecs[15].o = '0;
        vecs[16].i = '{inst_req:1'b1, pc:32'h104, mrvalid:1'b1, mrdata:32'h77777777,
                       rd_ack:1'b1, inst_ack:1'b1, default:'0};
        vecs[16].o = '{mem_read:1'b1, mem_address:32'h104, default:'0};
        vecs[17].i = '{inst_req:1'b1, pc:32'h104, mreq_ack:1'b1, default:'0};
        vecs[17].o = '{mem_read:1'b1, mem_address:32'h104, i_req_ack:1'b1, default:'0};
        vecs[18].i = '{mrvalid:1'b1, mrdata:32'h0BADF00D, inst_ack:1'b1, default:'0};
        vecs[18].o = '{inst_valid:1'b1, instruction:32'h0BADF00D, mem_rd_ack:1'b1, default:'0};
        vecs[19].i = '{inst_req:1'b1, pc:32'h108, rd:1'b1, addr:32'h4000, default:'0};
        vecs[19].o = '0;
        vecs[20].i = vecs[19].i;
        vecs[20].o = '{mem_read:1'b1, mem_address:32'h4000, default:'0};

        do_reset();
        chk_out("reset_outputs", sample(), '0);
        chk("reset_perf", perf_inst_grants | perf_data_grants | perf_wait_cycles, 32'd0);

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].i);
            @(negedge clk);
            chk_out($sformatf("vec%0d", k), sample(), vecs[k].o);
            @(posedge clk); #1;
        end

        // Tie out of reset, then ten fully contended fetch/data-read pairs.
        do_reset();
        cpu_inst_req_valid = 1'b1; cpu_pc = 32'h0001_0000;
        cpu_mem_read = 1'b1; cpu_address = 32'h0008_0000;
        for (int k = 0; k < 10; k++) begin
            run_read(1'b0, 32'h0008_0000 + 32'(4*k), 32'hD000_0000 + 32'(k),
                     $sformatf("pair%0d_D", k));
            if (k < 9) begin
                cpu_mem_read = 1'b1; cpu_address = 32'h0008_0000 + 32'(4*(k+1));
            end
            run_read(1'b1, 32'h0001_0000 + 32'(4*k), 32'h1000_0000 + 32'(k),
                     $sformatf("pair%0d_I", k));
            if (k < 9) begin
                cpu_inst_req_valid = 1'b1; cpu_pc = 32'h0001_0000 + 32'(4*(k+1));
            end
`ifdef ARB_PERF_CNT_EN
            if (k == 0) begin
                chk("tie_inst_grants", perf_inst_grants, 32'd1);
                chk("tie_data_grants", perf_data_grants, 32'd1);
                chk("tie_wait_nonzero", {31'd0, perf_wait_cycles >= 32'd1}, 32'd1);
            end
`endif
        end
`ifdef ARB_PERF_CNT_EN
        chk("pairs_inst_grants", perf_inst_grants, 32'd10);
        chk("pairs_data_grants", perf_data_grants, 32'd10);
`else
        chk("perf_off_zero", perf_inst_grants | perf_data_grants | perf_wait_cycles, 32'd0);
`endif

        // Reset asserted while a data read is in its response phase.
        cpu_mem_read = 1'b1; cpu_address = 32'h5000;
        @(posedge clk); #1;
        mem_req_ack = 1'b1;
        @(posedge clk); #1;
        mem_req_ack = 1'b0; cpu_mem_read = 1'b0;
        mem_read_data_valid = 1'b1; mem_read_data = 32'hA5A5A5A5; cpu_read_data_ack = 1'b1;
        #2;
        chk("dresp_before_reset", {31'd0, cpu_read_data_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk_out("reset_mid_dresp", sample(), '0);
        chk("reset_mid_perf", perf_inst_grants | perf_data_grants | perf_wait_cycles, 32'd0);
        drive('0);
        @(posedge clk); #1;
        rst = 1'b1;
        cpu_inst_req_valid = 1'b1; cpu_pc = 32'h0000_0200;
        run_read(1'b1, 32'h0000_0200, 32'h3C01_1234, "post_reset_fetch");

`ifdef ARB_PERF_CNT_EN
        // Wrap of the fetch grant counter.
        force dut.inst_cnt = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.inst_cnt;
        cpu_inst_req_valid = 1'b1; cpu_pc = 32'h0000_0300;
        run_read(1'b1, 32'h0000_0300, 32'h0000_0001, "wrap_fetch");
        chk("inst_grants_wrap", perf_inst_grants, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
